// File: rtl/branch_resolution_unit.sv
// In-order queue of decode-stage branch predictions, checked against mem-stage outcomes.
// Optional macro BRU_STATS_EN adds saturating branch/mispredict counters.
module branch_resolution_unit #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int GHR_W  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     push_pred,
  input  logic [ADDR_W-1:0]        push_target,
  input  logic [ADDR_W-1:0]        push_fallthrough,
  input  logic [GHR_W-1:0]         push_ghr,
  input  logic                     resolve,
  input  logic                     resolve_taken,
  output logic                     update_valid,
  output logic                     update_taken,
  output logic                     mispredict,
  output logic [ADDR_W-1:0]        redirect_pc,
  output logic [GHR_W-1:0]         ghr_restore,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
`ifdef BRU_STATS_EN
  output logic [15:0]              stat_branches,
  output logic [15:0]              stat_mispredicts,
`endif
  output logic                     overflow,
  output logic                     underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic              pred_q   [DEPTH];
  logic [ADDR_W-1:0] target_q [DEPTH];
  logic [ADDR_W-1:0] fall_q   [DEPTH];
  logic [GHR_W-1:0]  ghr_q    [DEPTH];

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              pop;
  logic              mis_now;
  logic              push_ok;
  logic              push_rej;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == {CNT_W{1'b0}});

  // A mispredicting pop squashes any same-cycle push without flagging overflow.
  always_comb begin
    pop      = resolve && !empty;
    mis_now  = pop && (pred_q[rd_ptr] != resolve_taken);
    push_ok  = push && !mis_now && (!full || pop);
    push_rej = push && full && !pop;
  end

  // Entry storage; slot contents are meaningful only between push and pop.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      pred_q[wr_ptr]   <= push_pred;
      target_q[wr_ptr] <= push_target;
      fall_q[wr_ptr]   <= push_fallthrough;
      ghr_q[wr_ptr]    <= push_ghr;
    end
  end

  // Pointers, occupancy, sticky error flags and registered resolution outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr       <= {PTR_W{1'b0}};
      rd_ptr       <= {PTR_W{1'b0}};
      count        <= {CNT_W{1'b0}};
      overflow     <= 1'b0;
      underflow    <= 1'b0;
      update_valid <= 1'b0;
      update_taken <= 1'b0;
      mispredict   <= 1'b0;
      redirect_pc  <= {ADDR_W{1'b0}};
      ghr_restore  <= {GHR_W{1'b0}};
    end else begin
      if (push_rej) overflow <= 1'b1;
      if (resolve && empty) underflow <= 1'b1;

      if (mis_now) begin
        rd_ptr <= wr_ptr;
        count  <= {CNT_W{1'b0}};
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + 1'b1;
        if (pop)     rd_ptr <= rd_ptr + 1'b1;
        case ({push_ok, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end

      update_valid <= pop;
      update_taken <= pop && resolve_taken;
      mispredict   <= mis_now;
      if (mis_now) begin
        redirect_pc <= resolve_taken ? target_q[rd_ptr] : fall_q[rd_ptr];
        ghr_restore <= {ghr_q[rd_ptr][GHR_W-2:0], resolve_taken};
      end else begin
        redirect_pc <= {ADDR_W{1'b0}};
        ghr_restore <= {GHR_W{1'b0}};
      end
    end
  end

`ifdef BRU_STATS_EN
  // Saturating resolution statistics.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_branches    <= 16'h0000;
      stat_mispredicts <= 16'h0000;
    end else begin
      if (pop && stat_branches != 16'hFFFF) stat_branches <= stat_branches + 16'h0001;
      if (mis_now && stat_mispredicts != 16'hFFFF) stat_mispredicts <= stat_mispredicts + 16'h0001;
    end
  end
`endif

endmodule
